// File: rtl/csr_unit_if.sv
// Writeback-to-CSR bus: CSR read/write port plus exception/ERTN commit info.
interface csr_unit_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] wb_pc;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_vaddr;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
    input  csr_rvalue
  );
  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
    output csr_rvalue
  );
endinterface

// File: rtl/csr_unit.sv
// Per-core CSR file: CSR read/write, exception/ERTN state capture,
// interrupt sampling and the constant timer.
// Optional timer (TCFG/TVAL/TICLR, TI) is built only when CSR_TIMER_EN is defined.
module csr_unit #(
  parameter logic [31:0] COREID = 32'd0
) (
  input  logic              clk,
  input  logic              resetn,
  csr_unit_if.slave         bus,
  input  logic [7:0]        hw_int_in,
  input  logic              ipi_int_in,
  output logic              has_int,
  output logic [31:0]       ex_entry,
  output logic [31:0]       ertn_entry
);
  localparam logic [13:0] A_CRMD = 14'h0, A_PRMD = 14'h1, A_ECFG = 14'h4, A_ESTAT = 14'h5;
  localparam logic [13:0] A_ERA = 14'h6, A_BADV = 14'h7, A_EENTRY = 14'hC, A_SAVE0 = 14'h30;
  localparam logic [13:0] A_TID = 14'h40, A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44;
  localparam logic [12:0] LIE_WR = 13'h1BFF;  // LIE bit 10 is hardwired 0

  logic        we;
  logic [13:0] num;
  logic [31:0] wm, wv;
  assign we  = bus.csr_we;
  assign num = bus.csr_num;
  assign wm  = bus.csr_wmask;
  assign wv  = bus.csr_wvalue;

  logic [3:0]       crmd_q, crmd_d;
  logic [2:0]       prmd_q, prmd_d;
  logic [12:0]      lie_q, lie_d;
  logic [1:0]       is_sw_q, is_sw_d;
  logic [7:0]       is_hw_q, is_hw_d;
  logic             is_ipi_q, is_ipi_d;
  logic [5:0]       ecode_q, ecode_d;
  logic [8:0]       esub_q, esub_d;
  logic [31:0]      era_q, era_d, badv_q, badv_d, tid_q, tid_d;
  logic [25:0]      eentry_q, eentry_d;
  logic [3:0][31:0] save_q, save_d;
  logic             ti;
  logic             badv_pc, badv_va;

  assign badv_pc = (bus.wb_ecode == 6'h8) && (bus.wb_esubcode == 9'h0);
  assign badv_va = (bus.wb_ecode == 6'h9) || ((bus.wb_ecode == 6'h8) && (bus.wb_esubcode == 9'h1));

  // Next state: software write first, commit effects override the fields they own.
  always_comb begin
    crmd_d   = crmd_q;
    prmd_d   = prmd_q;
    lie_d    = lie_q;
    is_sw_d  = is_sw_q;
    is_hw_d  = hw_int_in;
    is_ipi_d = ipi_int_in;
    ecode_d  = ecode_q;
    esub_d   = esub_q;
    era_d    = era_q;
    badv_d   = badv_q;
    eentry_d = eentry_q;
    save_d   = save_q;
    tid_d    = tid_q;
    if (we && num == A_CRMD)   crmd_d   = (crmd_q & ~wm[3:0]) | (wv[3:0] & wm[3:0]);
    if (we && num == A_PRMD)   prmd_d   = (prmd_q & ~wm[2:0]) | (wv[2:0] & wm[2:0]);
    if (we && num == A_ECFG)   lie_d    = (lie_q & ~(wm[12:0] & LIE_WR)) | (wv[12:0] & wm[12:0] & LIE_WR);
    if (we && num == A_ESTAT)  is_sw_d  = (is_sw_q & ~wm[1:0]) | (wv[1:0] & wm[1:0]);
    if (we && num == A_ERA)    era_d    = (era_q & ~wm) | (wv & wm);
    if (we && num == A_BADV)   badv_d   = (badv_q & ~wm) | (wv & wm);
    if (we && num == A_EENTRY) eentry_d = (eentry_q & ~wm[31:6]) | (wv[31:6] & wm[31:6]);
    if (we && num == A_TID)    tid_d    = (tid_q & ~wm) | (wv & wm);
    for (int i = 0; i < 4; i++)
      if (we && num == A_SAVE0 + 14'(i)) save_d[i] = (save_q[i] & ~wm) | (wv & wm);
    if (bus.wb_ex) begin
      prmd_d      = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      era_d       = bus.wb_pc;
      ecode_d     = bus.wb_ecode;
      esub_d      = bus.wb_esubcode;
      if (badv_pc) badv_d = bus.wb_pc;
      if (badv_va) badv_d = bus.wb_vaddr;
    end else if (bus.ertn_flush) begin
      crmd_d[2:0] = prmd_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      crmd_q   <= 4'h8;
      prmd_q   <= '0;
      lie_q    <= '0;
      is_sw_q  <= '0;
      is_hw_q  <= '0;
      is_ipi_q <= 1'b0;
      ecode_q  <= '0;
      esub_q   <= '0;
      era_q    <= '0;
      badv_q   <= '0;
      eentry_q <= '0;
      save_q   <= '0;
      tid_q    <= COREID;
    end else begin
      crmd_q   <= crmd_d;
      prmd_q   <= prmd_d;
      lie_q    <= lie_d;
      is_sw_q  <= is_sw_d;
      is_hw_q  <= is_hw_d;
      is_ipi_q <= is_ipi_d;
      ecode_q  <= ecode_d;
      esub_q   <= esub_d;
      era_q    <= era_d;
      badv_q   <= badv_d;
      eentry_q <= eentry_d;
      save_q   <= save_d;
      tid_q    <= tid_d;
    end
  end

`ifdef CSR_TIMER_EN
  logic [31:0] tcfg_q, tcfg_d, tval_q, tval_d;
  logic        ti_q, ti_d;

  // Timer: countdown/reload, TCFG write reloads TVAL, TI set beats TICLR clear.
  always_comb begin
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    ti_d   = ti_q;
    if (tcfg_q[0] && tval_q != 32'hFFFF_FFFF) begin
      if (tval_q == 32'h0) tval_d = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'hFFFF_FFFF;
      else                 tval_d = tval_q - 32'h1;
    end
    if (we && num == A_TCFG) begin
      tcfg_d = (tcfg_q & ~wm) | (wv & wm);
      tval_d = {tcfg_d[31:2], 2'b00};
    end
    if (we && num == A_TICLR && wm[0] && wv[0]) ti_d = 1'b0;
    if (tcfg_q[0] && tval_q == 32'h0) ti_d = 1'b1;
  end

  // Timer registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcfg_q <= '0;
      tval_q <= '0;
      ti_q   <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end
  assign ti = ti_q;
`else
  assign ti = 1'b0;
`endif

  logic [12:0] is_all;
  logic [31:0] rdata;
  assign is_all = {is_ipi_q, ti, 1'b0, is_hw_q, is_sw_q};

  // Zero-latency read mux; unimplemented indices and TICLR read 0.
  always_comb begin
    rdata = '0;
    if (bus.csr_re) begin
      case (num)
        A_CRMD:   rdata = {28'h0, crmd_q};
        A_PRMD:   rdata = {29'h0, prmd_q};
        A_ECFG:   rdata = {19'h0, lie_q};
        A_ESTAT:  rdata = {1'b0, esub_q, ecode_q, 3'b000, is_all};
        A_ERA:    rdata = era_q;
        A_BADV:   rdata = badv_q;
        A_EENTRY: rdata = {eentry_q, 6'h0};
        14'h30, 14'h31, 14'h32, 14'h33: rdata = save_q[num[1:0]];
        A_TID:    rdata = tid_q;
`ifdef CSR_TIMER_EN
        A_TCFG:   rdata = tcfg_q;
        A_TVAL:   rdata = tval_q;
`endif
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.csr_rvalue = rdata;
  assign has_int        = (|(is_all & lie_q)) & crmd_q[2];
  assign ex_entry       = {eentry_q, 6'h0};
  assign ertn_entry     = era_q;
endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed literal checks plus a randomized
// phase, all compared against a word-level CSR model held in the bench.
module tb_csr_unit;
  localparam logic [31:0] CID = 32'h5;
  logic clk = 1'b0, resetn = 1'b0;
  logic [7:0] hw_int_in = '0;
  logic ipi_int_in = 1'b0, has_int;
  logic [31:0] ex_entry, ertn_entry;
  csr_unit_if bus();

  csr_unit #(.COREID(CID)) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
    .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry));

  always #5 clk = ~clk;

  // Model: every CSR index holds its architecturally visible 32-bit word.
  logic [31:0] m [0:16383];
  int n_checks = 0, n_errors = 0;
  bit chk_en = 0, lit_en = 0, hi_en = 0, hi_val = 0;
  logic [31:0] lit_val = '0;
  string lit_name = "";

  function automatic logic [31:0] wmask_of(input logic [13:0] n);
    case (n)
      14'h0: return 32'hF;
      14'h1: return 32'h7;
      14'h4: return 32'h1BFF;
      14'h5: return 32'h3;
      14'h6, 14'h7, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40: return 32'hFFFF_FFFF;
      14'hC: return 32'hFFFF_FFC0;
`ifdef CSR_TIMER_EN
      14'h41: return 32'hFFFF_FFFF;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16384; i++) m[i] = 32'h0;
    m[14'h0]  = 32'h8;
    m[14'h40] = CID;
  endtask

  task automatic model_step();
    logic [31:0] o_crmd, o_prmd, o_tcfg, o_tval, wmk;
    o_crmd = m[14'h0]; o_prmd = m[14'h1]; o_tcfg = m[14'h41]; o_tval = m[14'h42];
    if (!resetn) begin model_reset(); return; end
    if (bus.csr_we) begin
      wmk = bus.csr_wmask & wmask_of(bus.csr_num);
      m[bus.csr_num] = (m[bus.csr_num] & ~wmk) | (bus.csr_wvalue & wmk);
    end
    m[14'h5][9:2] = hw_int_in;
    m[14'h5][12]  = ipi_int_in;
`ifdef CSR_TIMER_EN
    if (o_tcfg[0] && o_tval != 32'hFFFF_FFFF)
      m[14'h42] = (o_tval != 0) ? o_tval - 1 : (o_tcfg[1] ? (o_tcfg & 32'hFFFF_FFFC) : 32'hFFFF_FFFF);
    if (bus.csr_we && bus.csr_num == 14'h41) m[14'h42] = m[14'h41] & 32'hFFFF_FFFC;
    if (bus.csr_we && bus.csr_num == 14'h44 && bus.csr_wmask[0] && bus.csr_wvalue[0]) m[14'h5][11] = 1'b0;
    if (o_tcfg[0] && o_tval == 0) m[14'h5][11] = 1'b1;
`else
    o_tcfg = o_tval;  // timer words stay 0 in this build
`endif
    if (bus.wb_ex) begin
      m[14'h1][2:0]   = o_crmd[2:0];
      m[14'h0][2:0]   = 3'b000;
      m[14'h6]        = bus.wb_pc;
      m[14'h5][21:16] = bus.wb_ecode;
      m[14'h5][30:22] = bus.wb_esubcode;
      if (bus.wb_ecode == 6'h8 && bus.wb_esubcode == 9'h0) m[14'h7] = bus.wb_pc;
      else if (bus.wb_ecode == 6'h9 || (bus.wb_ecode == 6'h8 && bus.wb_esubcode == 9'h1)) m[14'h7] = bus.wb_vaddr;
    end else if (bus.ertn_flush) begin
      m[14'h0][2:0] = o_prmd[2:0];
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: DUT vs model every cycle, plus literal pins.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    logic exp_hi;
    if (chk_en) begin
      exp_rd = bus.csr_re ? m[bus.csr_num] : 32'h0;
      exp_hi = (|(m[14'h5][12:0] & m[14'h4][12:0])) & m[14'h0][2];
      cmp("rvalue", bus.csr_rvalue, exp_rd);
      cmp("has_int", {31'h0, has_int}, {31'h0, exp_hi});
      cmp("ex_entry", ex_entry, m[14'hC]);
      cmp("ertn_entry", ertn_entry, m[14'h6]);
      if (lit_en) begin
        cmp(lit_name, bus.csr_rvalue, lit_val);
        cmp({lit_name, "_model"}, exp_rd, lit_val);
      end
      if (hi_en) cmp("has_int_lit", {31'h0, has_int}, {31'h0, hi_val});
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    lit_en = 0; hi_en = 0;
    bus.csr_we = 0; bus.wb_ex = 0; bus.ertn_flush = 0;
  endtask

  task automatic rd(input string nm, input logic [13:0] n, input logic [31:0] e);
    bus.csr_re = 1; bus.csr_num = n; lit_en = 1; lit_name = nm; lit_val = e;
    step();
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] mk);
    bus.csr_re = 1; bus.csr_num = n; bus.csr_we = 1; bus.csr_wvalue = v; bus.csr_wmask = mk;
    step();
  endtask

  task automatic ex(input logic [5:0] ec, input logic [8:0] es, input logic [31:0] pc, input logic [31:0] va);
    bus.wb_ex = 1; bus.wb_ecode = ec; bus.wb_esubcode = es; bus.wb_pc = pc; bus.wb_vaddr = va;
    step();
  endtask

  logic [13:0] nums [16] = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC, 14'h30,
                             14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h2, 14'h45, 14'h3FFF};

  initial begin
    bus.csr_re = 0; bus.csr_num = '0; bus.csr_we = 0; bus.csr_wmask = '0; bus.csr_wvalue = '0;
    bus.wb_ex = 0; bus.ertn_flush = 0; bus.wb_pc = '0; bus.wb_ecode = '0; bus.wb_esubcode = '0;
    bus.wb_vaddr = '0;
    resetn = 0;
    step(); step();
    resetn = 1; chk_en = 1;

    // Reset values
    hi_en = 1; hi_val = 0;
    rd("rst_crmd", 14'h0, 32'h8);
    rd("rst_estat", 14'h5, 32'h0);
    rd("rst_era", 14'h6, 32'h0);
    rd("rst_eentry", 14'hC, 32'h0);
    rd("rst_tid", 14'h40, CID);

    // Masked write, exception entry, ERTN
    wr(14'h0, 32'h7, 32'h3);
    rd("crmd_wr", 14'h0, 32'hB);
    ex(6'h9, 9'h0, 32'h1C00_0100, 32'h1003);
    rd("crmd_ex", 14'h0, 32'h8);
    rd("prmd_ex", 14'h1, 32'h3);
    rd("era_ex", 14'h6, 32'h1C00_0100);
    rd("badv_ale", 14'h7, 32'h1003);
    rd("estat_ex", 14'h5, 32'h0009_0000);
    bus.ertn_flush = 1; step();
    rd("crmd_ertn", 14'h0, 32'hB);

    // Commit beats software write on ERA; unrelated SAVE0 write still lands
    wr(14'hC, 32'h1234_5678, 32'hFFFF_FFFF);
    rd("eentry", 14'hC, 32'h1234_5640);
    bus.csr_we = 1; bus.csr_num = 14'h6; bus.csr_wvalue = 32'h55; bus.csr_wmask = 32'hFFFF_FFFF;
    ex(6'h8, 9'h0, 32'h1C00_0200, 32'h77);
    rd("era_prio", 14'h6, 32'h1C00_0200);
    rd("badv_adef", 14'h7, 32'h1C00_0200);
    bus.csr_we = 1; bus.csr_num = 14'h30; bus.csr_wvalue = 32'hABCD; bus.csr_wmask = 32'hFFFF_FFFF;
    ex(6'h1, 9'h0, 32'h1C00_0300, 32'hDEAD);
    rd("save0_with_ex", 14'h30, 32'hABCD);
    rd("badv_keep", 14'h7, 32'h1C00_0200);
    rd("estat_ec1", 14'h5, 32'h0001_0000);

    // Interrupt path
    wr(14'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("ecfg_bit10", 14'h4, 32'h1BFF);
    wr(14'h4, 32'h4, 32'hFFFF_FFFF);
    wr(14'h0, 32'h4, 32'h4);
    rd("crmd_ie", 14'h0, 32'hC);
    hw_int_in = 8'h1; hi_en = 1; hi_val = 0; step();
    hi_en = 1; hi_val = 1; wr(14'h0, 32'h0, 32'h4);
    hi_en = 1; hi_val = 0; step();
    hw_int_in = 8'h0; step(); step();

`ifdef CSR_TIMER_EN
    wr(14'h41, 32'h13, 32'hFFFF_FFFF);
    for (int i = 0; i <= 16; i++) rd("tval_per", 14'h42, 32'(16 - i));
    rd("estat_ti", 14'h5, 32'h0001_0800);
    rd("tval_reload", 14'h42, 32'd15);
    wr(14'h44, 32'h1, 32'h1);
    rd("estat_ticlr", 14'h5, 32'h0001_0000);
    wr(14'h41, 32'h9, 32'hFFFF_FFFF);
    for (int i = 0; i <= 8; i++) rd("tval_one", 14'h42, 32'(8 - i));
    rd("tval_ff", 14'h42, 32'hFFFF_FFFF);
    rd("tval_hold", 14'h42, 32'hFFFF_FFFF);
    wr(14'h44, 32'h1, 32'h1);
    wr(14'h41, 32'h0, 32'hFFFF_FFFF);
`else
    wr(14'h41, 32'h13, 32'hFFFF_FFFF);
    rd("tcfg_off", 14'h41, 32'h0);
    rd("tval_off", 14'h42, 32'h0);
    repeat (20) step();
    rd("estat_noti", 14'h5, 32'h0001_0000);
`endif

    // Randomized phase
    for (int c = 0; c < 4000; c++) begin
      resetn = ($urandom_range(0, 299) != 0);
      bus.csr_re = ($urandom_range(0, 7) != 0);
      bus.csr_num = nums[$urandom_range(0, 15)];
      bus.csr_we = ($urandom_range(0, 2) == 0) && (bus.csr_num != 14'h40);
      bus.csr_wmask = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.csr_wvalue = (bus.csr_num == 14'h41) ? 32'($urandom_range(0, 127)) : $urandom;
      bus.wb_ex = ($urandom_range(0, 15) == 0);
      bus.ertn_flush = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: bus.wb_ecode = 6'h8;
        1: bus.wb_ecode = 6'h9;
        default: bus.wb_ecode = 6'($urandom);
      endcase
      bus.wb_esubcode = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'($urandom_range(0, 1));
      bus.wb_pc = $urandom;
      bus.wb_vaddr = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int_in = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ipi_int_in = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
